// File: rtl/fft_stage_ctrl.sv
// Control sequencer for one radix-2 SDF FFT stage: frame counting, fill/butterfly/drain
// mode switching, twiddle addressing and output qualification, with a one-cycle output lag.
module fft_stage_ctrl #(
    parameter int N     = 8,
    parameter int TW_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             buf_shift,
    output logic             bf_en,
    output logic             tw_rd,
    output logic [TW_AW-1:0] tw_addr,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             drain_done
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] HALF_LAST = IW'(N / 2 - 1);
    localparam logic [IW-1:0] LAST      = IW'(N - 1);

    typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

    state_t           state_reg;
    logic [IW-1:0]    idx_reg;
    logic             primed_reg;
    logic             flush_pend_reg;
    logic             buf_shift_reg;
    logic             bf_en_reg;
    logic             tw_rd_reg;
    logic [TW_AW-1:0] tw_addr_reg;
    logic             dout_valid_reg;
    logic             frame_done_reg;
    logic             drain_done_reg;

    logic at_start;
    logic drain_start;
    logic adv;

    assign at_start    = (state_reg == FILL) && (idx_reg == '0);
    // A primed buffer with a pending flush stalls intake for the one cycle that switches to DRAIN.
    assign drain_start = at_start && flush_pend_reg && primed_reg;
    assign din_ready   = (state_reg != DRAIN) && !drain_start;
    assign adv         = (din_valid && din_ready) || (state_reg == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            idx_reg        <= '0;
            primed_reg     <= 1'b0;
            flush_pend_reg <= 1'b0;
            buf_shift_reg  <= 1'b0;
            bf_en_reg      <= 1'b0;
            tw_rd_reg      <= 1'b0;
            tw_addr_reg    <= '0;
            dout_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            drain_done_reg <= 1'b0;
        end else begin
            buf_shift_reg  <= adv;
            bf_en_reg      <= adv && (state_reg == BFLY);
            tw_rd_reg      <= adv && (state_reg == BFLY);
            dout_valid_reg <= adv && ((state_reg == BFLY) || primed_reg);
            frame_done_reg <= 1'b0;
            drain_done_reg <= 1'b0;
            if (adv && (state_reg == BFLY)) begin
                tw_addr_reg <= idx_reg[TW_AW-1:0];
            end

            // Later clears below override this set, so a flush coinciding with a clear is absorbed.
            if (flush) begin
                flush_pend_reg <= 1'b1;
            end

            case (state_reg)
                FILL: begin
                    if (drain_start) begin
                        state_reg <= DRAIN;
                    end else begin
                        if (at_start && flush_pend_reg) begin
                            flush_pend_reg <= 1'b0;
                            drain_done_reg <= 1'b1;
                        end
                        if (adv) begin
                            idx_reg <= idx_reg + IW'(1);
                            if (idx_reg == HALF_LAST) begin
                                state_reg <= BFLY;
                            end
                        end
                    end
                end
                BFLY: begin
                    if (adv) begin
                        if (idx_reg == LAST) begin
                            idx_reg        <= '0;
                            primed_reg     <= 1'b1;
                            frame_done_reg <= 1'b1;
                            state_reg      <= (flush_pend_reg || flush) ? DRAIN : FILL;
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (idx_reg == HALF_LAST) begin
                        state_reg      <= FILL;
                        idx_reg        <= '0;
                        primed_reg     <= 1'b0;
                        flush_pend_reg <= 1'b0;
                        drain_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                default: begin
                    state_reg <= FILL;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    assign buf_shift  = buf_shift_reg;
    assign bf_en      = bf_en_reg;
    assign tw_rd      = tw_rd_reg;
    assign tw_addr    = tw_addr_reg;
    assign dout_valid = dout_valid_reg;
    assign frame_done = frame_done_reg;
    assign drain_done = drain_done_reg;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: a frame-position model checked every cycle, plus directed
// scenarios whose pulse counts and cycle positions are pinned with literal values.
module tb_fft_stage_ctrl;
    localparam int N     = 8;
    localparam int TW_AW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             flush = 1'b0;
    logic             buf_shift;
    logic             bf_en;
    logic             tw_rd;
    logic [TW_AW-1:0] tw_addr;
    logic             dout_valid;
    logic             frame_done;
    logic             drain_done;

    fft_stage_ctrl #(.N(N), .TW_AW(TW_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .flush      (flush),
        .buf_shift  (buf_shift),
        .bf_en      (bf_en),
        .tw_rd      (tw_rd),
        .tw_addr    (tw_addr),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: position within frame, remaining drain advances, buffer-primed and flush-pending flags.
    int               m_pos   = 0;
    int               m_drain = 0;
    bit               m_primed = 1'b0;
    bit               m_pend   = 1'b0;
    bit               m_second;
    logic             e_shift = 1'b0, e_bf = 1'b0, e_dv = 1'b0, e_fd = 1'b0, e_dd = 1'b0;
    logic [TW_AW-1:0] e_tw = '0;

    always @(posedge clk) begin
        e_shift = 1'b0; e_bf = 1'b0; e_dv = 1'b0; e_fd = 1'b0; e_dd = 1'b0;
        if (rst) begin
            m_pos = 0; m_drain = 0; m_primed = 1'b0; m_pend = 1'b0; e_tw = '0;
        end else if (m_drain > 0) begin
            e_shift = 1'b1;
            e_dv    = m_primed;
            m_drain--;
            if (m_drain == 0) begin
                m_primed = 1'b0; m_pend = 1'b0; e_dd = 1'b1;
            end
        end else if (m_pos == 0 && m_pend && m_primed) begin
            m_drain = N / 2;
        end else begin
            if (m_pos == 0 && m_pend) begin
                m_pend = 1'b0; e_dd = 1'b1;
            end else if (flush) begin
                m_pend = 1'b1;
            end
            if (din_valid) begin
                m_second = (m_pos >= N / 2);
                e_shift  = 1'b1;
                e_bf     = m_second;
                e_dv     = m_second || m_primed;
                if (m_second) e_tw = TW_AW'(m_pos - N / 2);
                if (m_pos == N - 1) begin
                    m_pos = 0; m_primed = 1'b1; e_fd = 1'b1;
                    if (m_pend) m_drain = N / 2;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // Per-scenario observation counters used by the literal checks.
    int cyc, cnt_shift, cnt_dv, cnt_bf, cnt_fd, cnt_dd, cnt_nr, first_bf, first_dv, fd_cyc, dd_cyc, tw_n;
    int tw_log [0:15];

    task automatic clear_obs();
        cyc = 0; cnt_shift = 0; cnt_dv = 0; cnt_bf = 0; cnt_fd = 0; cnt_dd = 0; cnt_nr = 0;
        first_bf = 0; first_dv = 0; fd_cyc = 0; dd_cyc = 0; tw_n = 0;
    endtask

    always @(negedge clk) begin
        chk("buf_shift", int'(buf_shift), int'(e_shift));
        chk("bf_en", int'(bf_en), int'(e_bf));
        chk("tw_rd", int'(tw_rd), int'(e_bf));
        chk("tw_addr", int'(tw_addr), int'(e_tw));
        chk("dout_valid", int'(dout_valid), int'(e_dv));
        chk("frame_done", int'(frame_done), int'(e_fd));
        chk("drain_done", int'(drain_done), int'(e_dd));
        chk("din_ready", int'(din_ready), int'((m_drain == 0) && !(m_pos == 0 && m_pend && m_primed)));
        cyc++;
        if (buf_shift) cnt_shift++;
        if (dout_valid) begin cnt_dv++; if (first_dv == 0) first_dv = cyc; end
        if (bf_en) begin cnt_bf++; if (first_bf == 0) first_bf = cyc; end
        if (frame_done) begin cnt_fd++; fd_cyc = cyc; end
        if (drain_done) begin cnt_dd++; dd_cyc = cyc; end
        if (!din_ready) cnt_nr++;
        if (tw_rd && tw_n < 16) begin tw_log[tw_n] = int'(tw_addr); tw_n++; end
    end

    task automatic step(input logic v, input logic f, input logic r);
        din_valid = v; flush = f; rst = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run_b2b();
        clear_obs();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
        chk("b2b_shift_cnt", cnt_shift, 8);
        chk("b2b_bf_cnt", cnt_bf, 4);
        chk("b2b_first_bf", first_bf, 5);
        chk("b2b_dv_cnt", cnt_dv, 4);
        chk("b2b_first_dv", first_dv, 5);
        chk("b2b_fd_cyc", fd_cyc, 8);
        chk("b2b_fd_cnt", cnt_fd, 1);
        chk("b2b_tw_n", tw_n, 4);
        for (int i = 0; i < 4; i++) chk("b2b_tw_seq", tw_log[i], i);
        step(1'b0, 1'b0, 1'b0);
        chk("b2b_idle_shift", int'(buf_shift), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs
        step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        din_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        chk("rst_outputs", int'({buf_shift, bf_en, tw_rd, dout_valid, frame_done, drain_done}), 0);
        chk("rst_tw_addr", int'(tw_addr), 0);
        chk("rst_ready", int'(din_ready), 1);

        run_b2b();

        // Gapped primed frame
        clear_obs();
        for (int i = 0; i < N; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("gap_shift_cnt", cnt_shift, 8);
        chk("gap_dv_cnt", cnt_dv, 8);
        chk("gap_bf_cnt", cnt_bf, 4);
        chk("gap_fd_cyc", fd_cyc, 15);
        chk("gap_tw_last", tw_log[3], 3);

        // Flush at idx 5 of a primed frame; din_valid held high through the drain
        clear_obs();
        for (int i = 0; i < N; i++) step(1'b1, (i == 5) ? 1'b1 : 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("mid_flush_fd_cyc", fd_cyc, 8);
        chk("mid_flush_nr", cnt_nr, 4);
        chk("mid_flush_shift", cnt_shift, 12);
        chk("mid_flush_dv", cnt_dv, 12);
        chk("mid_flush_bf", cnt_bf, 4);
        chk("mid_flush_dd_cyc", dd_cyc, 12);
        chk("mid_flush_dd_cnt", cnt_dd, 1);
        clear_obs();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
        chk("post_drain_first_dv", first_dv, 5);
        chk("post_drain_dv", cnt_dv, 4);

        // Flush while unprimed
        step(1'b0, 1'b0, 1'b1);
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("unprimed_dd_cyc", dd_cyc, 2);
        chk("unprimed_dd_cnt", cnt_dd, 1);
        chk("unprimed_shift", cnt_shift, 0);
        chk("unprimed_dv", cnt_dv, 0);
        chk("unprimed_nr", cnt_nr, 0);

        // Reset during BFLY idx 6
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        clear_obs();
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_outputs", int'({buf_shift, bf_en, tw_rd, dout_valid, frame_done, drain_done}), 0);
        chk("midrst_tw_addr", int'(tw_addr), 0);
        chk("midrst_ready", int'(din_ready), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("midrst_fd_cnt", cnt_fd, 0);
        run_b2b();

        // Flush coinciding with the final butterfly sample
        clear_obs();
        for (int i = 0; i < N; i++) step(1'b1, (i == N - 1) ? 1'b1 : 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        chk("last_flush_fd_cyc", fd_cyc, 8);
        chk("last_flush_nr", cnt_nr, 4);
        chk("last_flush_dd_cyc", dd_cyc, 12);

        // Flush from an idle primed FILL start, with din_valid ignored during the drain
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("idle_flush_dd_cyc", dd_cyc, 6);
        chk("idle_flush_nr", cnt_nr, 5);
        chk("idle_flush_shift", cnt_shift, 4);
        chk("idle_flush_dv", cnt_dv, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
